// File: rtl/mem_stage_hs.sv
// Memory-access pipeline stage: holds one instruction from EX, waits for its
// data-SRAM response, extracts/extends load data and feeds WB and ID forwarding.
module mem_stage_hs #(
  parameter int PC_W      = 32,
  parameter int RF_ADDR_W = 5,
  parameter int CANCEL_W  = 2
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            es_to_ms_valid,
  output logic                            ms_allowin,
  input  logic                            es_mem_req,
  input  logic [2:0]                      es_load_op,
  input  logic                            es_res_from_mem,
  input  logic                            es_gr_we,
  input  logic [RF_ADDR_W-1:0]            es_dest,
  input  logic [31:0]                     es_alu_result,
  input  logic [PC_W-1:0]                 es_pc,
  input  logic                            ws_allowin,
  output logic                            ms_to_ws_valid,
  output logic [1+RF_ADDR_W+32+PC_W-1:0]  ms_to_ws_bus,
  input  logic                            ms_flush,
  input  logic                            data_sram_data_ok,
  input  logic [31:0]                     data_sram_rdata,
  output logic                            ms_fwd_valid,
  output logic [RF_ADDR_W-1:0]            ms_fwd_dest,
  output logic [31:0]                     ms_fwd_data,
  output logic                            ms_fwd_stall
);

  localparam logic [CANCEL_W-1:0] CANCEL_MAX = '1;

  logic                 ms_valid_q, ms_valid_d;
  logic                 wait_data_q, wait_data_d;
  logic                 buf_valid_q, buf_valid_d;
  logic [31:0]          data_buf_q, data_buf_d;
  logic [CANCEL_W-1:0]  cancel_cnt_q, cancel_cnt_d;
  logic [2:0]           load_op_q, load_op_d;
  logic                 res_from_mem_q, res_from_mem_d;
  logic                 gr_we_q, gr_we_d;
  logic [RF_ADDR_W-1:0] dest_q, dest_d;
  logic [31:0]          alu_result_q, alu_result_d;
  logic [PC_W-1:0]      pc_q, pc_d;

  logic        cnt_zero, resp_ok, drop, consume, ms_ready_go;
  logic        handoff, capture, cancel_inc;
  logic [31:0] word, extracted, final_result;
  logic [7:0]  byte_lanes [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // A response only belongs to MS once every cancelled response has drained.
  assign cnt_zero    = (cancel_cnt_q == '0);
  assign resp_ok     = data_sram_data_ok && cnt_zero;
  assign drop        = data_sram_data_ok && !cnt_zero;
  assign consume     = ms_valid_q && wait_data_q && !buf_valid_q && resp_ok;
  assign ms_ready_go = !wait_data_q || buf_valid_q || resp_ok;
  assign ms_allowin  = !ms_valid_q || (ms_ready_go && ws_allowin);

  assign ms_to_ws_valid = ms_valid_q && ms_ready_go && !ms_flush;
  assign handoff        = ms_to_ws_valid && ws_allowin;
  assign capture        = es_to_ms_valid && ms_allowin && !ms_flush;
  assign cancel_inc     = ms_flush && ms_valid_q && wait_data_q && !buf_valid_q && !consume;

  assign word = buf_valid_q ? data_buf_q : data_sram_rdata;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign byte_lanes[gi] = word[8*gi +: 8];
    end
  endgenerate

  assign byte_sel = byte_lanes[alu_result_q[1:0]];
  assign half_sel = alu_result_q[1] ? word[31:16] : word[15:0];

  always_comb begin
    extracted = word;
    case (load_op_q)
      3'b001:  extracted = {{24{byte_sel[7]}}, byte_sel};
      3'b010:  extracted = {24'd0, byte_sel};
      3'b011:  extracted = {{16{half_sel[15]}}, half_sel};
      3'b100:  extracted = {16'd0, half_sel};
      default: extracted = word;
    endcase
  end

  assign final_result = res_from_mem_q ? extracted : alu_result_q;
  assign ms_to_ws_bus = {gr_we_q, dest_q, final_result, pc_q};

  assign ms_fwd_valid = ms_valid_q && gr_we_q && (dest_q != '0);
  assign ms_fwd_dest  = dest_q;
  assign ms_fwd_data  = final_result;
  assign ms_fwd_stall = ms_valid_q && res_from_mem_q && wait_data_q && !buf_valid_q && !resp_ok;

  always_comb begin
    ms_valid_d     = ms_valid_q;
    wait_data_d    = wait_data_q;
    buf_valid_d    = buf_valid_q;
    data_buf_d     = data_buf_q;
    load_op_d      = load_op_q;
    res_from_mem_d = res_from_mem_q;
    gr_we_d        = gr_we_q;
    dest_d         = dest_q;
    alu_result_d   = alu_result_q;
    pc_d           = pc_q;
    cancel_cnt_d   = cancel_cnt_q;

    if (ms_flush) begin
      ms_valid_d  = 1'b0;
      wait_data_d = 1'b0;
      buf_valid_d = 1'b0;
    end else if (capture) begin
      ms_valid_d     = 1'b1;
      wait_data_d    = es_mem_req;
      buf_valid_d    = 1'b0;
      load_op_d      = es_load_op;
      res_from_mem_d = es_res_from_mem;
      gr_we_d        = es_gr_we;
      dest_d         = es_dest;
      alu_result_d   = es_alu_result;
      pc_d           = es_pc;
    end else if (handoff) begin
      ms_valid_d  = 1'b0;
      wait_data_d = 1'b0;
      buf_valid_d = 1'b0;
    end else if (consume) begin
      // WB stalled: keep the word, rdata is only valid in the data_ok cycle.
      buf_valid_d = 1'b1;
      data_buf_d  = data_sram_rdata;
    end

    if (drop && !cancel_inc) begin
      cancel_cnt_d = cancel_cnt_q - CANCEL_W'(1);
    end else if (cancel_inc && !drop && (cancel_cnt_q != CANCEL_MAX)) begin
      cancel_cnt_d = cancel_cnt_q + CANCEL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ms_valid_q   <= 1'b0;
      wait_data_q  <= 1'b0;
      buf_valid_q  <= 1'b0;
      cancel_cnt_q <= '0;
    end else begin
      ms_valid_q   <= ms_valid_d;
      wait_data_q  <= wait_data_d;
      buf_valid_q  <= buf_valid_d;
      cancel_cnt_q <= cancel_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    data_buf_q     <= data_buf_d;
    load_op_q      <= load_op_d;
    res_from_mem_q <= res_from_mem_d;
    gr_we_q        <= gr_we_d;
    dest_q         <= dest_d;
    alu_result_q   <= alu_result_d;
    pc_q           <= pc_d;
  end

endmodule
